// File: rtl/ahbl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_pkg
// Description : AHB-Lite encodings and arbiter ownership type
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/ahbl_pend_slot.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_pend_slot
// Description : Holds one master's deferred address phase and its valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_pend_slot #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_write,
  input  logic [2:0]        in_size,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [2:0]        size
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      addr  <= '0;
      write <= 1'b0;
      size  <= 3'd0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= in_addr;
      write <= in_write;
      size  <= in_size;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_arb_2to1
// Description : Two-master to one-slave AHB-Lite single-transfer arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_arb_2to1
  import ahbl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        m0_htrans,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hreadyout,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic [1:0]        m1_htrans,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hreadyout,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic [1:0]        s_htrans,
  output logic [ADDR_W-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [DATA_W-1:0] s_hwdata,
  output logic              s_hready,
  input  logic              s_hreadyout,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hresp
);

  owner_t dph_owner;
  owner_t rr_last;
  owner_t winner;

  logic              live0, live1, req0, req1;
  logic              accept, fwd0, fwd1;
  logic              pend0_v, pend1_v;
  logic [ADDR_W-1:0] pend0_addr, pend1_addr;
  logic              pend0_write, pend1_write;
  logic [2:0]        pend0_size, pend1_size;
  logic [ADDR_W-1:0] sel_addr, hold_addr;
  logic              sel_write, hold_write;
  logic [2:0]        sel_size, hold_size;

  assign live0 = m0_htrans[1] & m0_hreadyout;
  assign live1 = m1_htrans[1] & m1_hreadyout;
  assign req0  = pend0_v | live0;
  assign req1  = pend1_v | live1;

  always_comb begin
    winner = NONE;
    if (req0 && req1) begin
      if (ARB_MODE == 0) winner = M1;
      else               winner = (rr_last == M1) ? M0 : M1;
    end else if (req1) begin
      winner = M1;
    end else if (req0) begin
      winner = M0;
    end
  end

  assign accept = s_hreadyout && (winner != NONE);
  assign fwd0   = accept && (winner == M0);
  assign fwd1   = accept && (winner == M1);

  // A pending entry always beats the same master's live bus.
  always_comb begin
    sel_addr  = hold_addr;
    sel_write = hold_write;
    sel_size  = hold_size;
    if (winner == M0) begin
      sel_addr  = pend0_v ? pend0_addr  : m0_haddr;
      sel_write = pend0_v ? pend0_write : m0_hwrite;
      sel_size  = pend0_v ? pend0_size  : m0_hsize;
    end else if (winner == M1) begin
      sel_addr  = pend1_v ? pend1_addr  : m1_haddr;
      sel_write = pend1_v ? pend1_write : m1_hwrite;
      sel_size  = pend1_v ? pend1_size  : m1_hsize;
    end
  end

  // While the slave stalls, the last accepted address is held and no transfer is issued.
  assign s_htrans = accept ? NONSEQ   : IDLE;
  assign s_haddr  = accept ? sel_addr  : hold_addr;
  assign s_hwrite = accept ? sel_write : hold_write;
  assign s_hsize  = accept ? sel_size  : hold_size;
  assign s_hready = s_hreadyout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dph_owner  <= NONE;
      rr_last    <= M0;
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= 3'd0;
    end else if (s_hreadyout) begin
      dph_owner <= winner;
      if (accept) begin
        rr_last    <= winner;
        hold_addr  <= sel_addr;
        hold_write <= sel_write;
        hold_size  <= sel_size;
      end
    end
  end

  ahbl_pend_slot #(.ADDR_W(ADDR_W)) u_pend0 (
    .clk      (clk),
    .rstn     (rstn),
    .capture  (live0 & ~fwd0),
    .clear    (fwd0),
    .in_addr  (m0_haddr),
    .in_write (m0_hwrite),
    .in_size  (m0_hsize),
    .valid    (pend0_v),
    .addr     (pend0_addr),
    .write    (pend0_write),
    .size     (pend0_size)
  );

  ahbl_pend_slot #(.ADDR_W(ADDR_W)) u_pend1 (
    .clk      (clk),
    .rstn     (rstn),
    .capture  (live1 & ~fwd1),
    .clear    (fwd1),
    .in_addr  (m1_haddr),
    .in_write (m1_hwrite),
    .in_size  (m1_hsize),
    .valid    (pend1_v),
    .addr     (pend1_addr),
    .write    (pend1_write),
    .size     (pend1_size)
  );

  always_comb begin
    m0_hreadyout = 1'b1;
    if (dph_owner == M0) m0_hreadyout = s_hreadyout;
    else if (pend0_v)    m0_hreadyout = 1'b0;
    m1_hreadyout = 1'b1;
    if (dph_owner == M1) m1_hreadyout = s_hreadyout;
    else if (pend1_v)    m1_hreadyout = 1'b0;
  end

  assign m0_hresp  = (dph_owner == M0) ? s_hresp : OKAY;
  assign m1_hresp  = (dph_owner == M1) ? s_hresp : OKAY;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  always_comb begin
    s_hwdata = '0;
    if (dph_owner == M0)      s_hwdata = m0_hwdata;
    else if (dph_owner == M1) s_hwdata = m1_hwdata;
  end

endmodule
`default_nettype wire
